// File: rtl/treasure_report_ctrl.sv
// Treasure report controller: turns per-frame shape/colour codes from the
// image processor into debounced reports, handed to the Arduino over a
// REPORT_VALID/ACK handshake that gives up after ACK_TIMEOUT cycles.
module treasure_report_ctrl #(
  parameter int SETTLE_FRAMES = 4,
  parameter int MATCH_FRAMES  = 3,
  parameter int ACK_TIMEOUT   = 2500000,
  parameter int TMO_W         = 22
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       VGA_VSYNC_NEG,
  input  logic [2:0] RESULT,
  input  logic       ACK,
  output logic [2:0] REPORT,
  output logic       REPORT_VALID,
  output logic       TIMEOUT_PULSE,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_VOTE    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int MW = $clog2(MATCH_FRAMES + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_FRAMES - 1);
  localparam logic [MW-1:0]    MATCH_MAX   = MW'(MATCH_FRAMES);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       last_q, last_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]       report_q, report_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;

  logic vs_meta_q, vs_meta_d;
  logic vs_sync_q, vs_sync_d;
  logic vs_prev_q, vs_prev_d;
  logic ack_meta_q, ack_meta_d;
  logic ack_sync_q, ack_sync_d;

  logic       frame_tick;
  logic [2:0] vote_code;

  // Synchroniser inputs: vsync gets a third stage so its rising edge can be seen
  always_comb begin
    vs_meta_d  = VGA_VSYNC_NEG;
    vs_sync_d  = vs_meta_q;
    vs_prev_d  = vs_sync_q;
    ack_meta_d = ACK;
    ack_sync_d = ack_meta_q;
  end

  // Vsync idles high, so its flops reset high to avoid a phantom frame after reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vs_meta_q  <= 1'b1;
      vs_sync_q  <= 1'b1;
      vs_prev_q  <= 1'b1;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      vs_meta_q  <= vs_meta_d;
      vs_sync_q  <= vs_sync_d;
      vs_prev_q  <= vs_prev_d;
      ack_meta_q <= ack_meta_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  // End of vsync marks a finished frame; the invalid code 111 votes as "nothing"
  assign frame_tick = vs_sync_q & ~vs_prev_q;
  assign vote_code  = (RESULT == 3'b111) ? 3'b000 : RESULT;

  // Next-state and datapath: settle, vote on consecutive codes, then handshake
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    match_cnt_d  = match_cnt_q;
    cand_d       = cand_q;
    last_d       = last_q;
    tmo_cnt_d    = tmo_cnt_q;
    report_d     = report_q;
    valid_d      = valid_q;
    pulse_d      = 1'b0;

    if (!ENABLE) begin
      state_d      = ST_IDLE;
      valid_d      = 1'b0;
      report_d     = 3'b000;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end

        ST_SETTLE: begin
          if (frame_tick) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d      = ST_VOTE;
              settle_cnt_d = '0;
              cand_d       = 3'b000;
              match_cnt_d  = '0;
            end else begin
              settle_cnt_d = settle_cnt_q + SW'(1);
            end
          end
        end

        ST_VOTE: begin
          if (frame_tick) begin
            if (vote_code == cand_q) begin
              match_cnt_d = (match_cnt_q == MATCH_MAX) ? MATCH_MAX : match_cnt_q + MW'(1);
            end else begin
              cand_d      = vote_code;
              match_cnt_d = MW'(1);
            end
            if (match_cnt_d == MATCH_MAX) begin
              if (cand_d == 3'b000) begin
                last_d = 3'b000;
              end else if (cand_d != last_q) begin
                report_d  = cand_d;
                valid_d   = 1'b1;
                tmo_cnt_d = '0;
                state_d   = ST_PRESENT;
              end
            end
          end
        end

        ST_PRESENT: begin
          if (ack_sync_q) begin
            valid_d = 1'b0;
            last_d  = report_q;
            state_d = ST_RELEASE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            valid_d     = 1'b0;
            pulse_d     = 1'b1;
            match_cnt_d = '0;
            state_d     = ST_VOTE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end

        ST_RELEASE: begin
          if (!ack_sync_q) begin
            match_cnt_d = '0;
            cand_d      = 3'b000;
            state_d     = ST_VOTE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Control state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      match_cnt_q  <= '0;
      cand_q       <= 3'b000;
      last_q       <= 3'b000;
      tmo_cnt_q    <= '0;
      report_q     <= 3'b000;
      valid_q      <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      cand_q       <= cand_d;
      last_q       <= last_d;
      tmo_cnt_q    <= tmo_cnt_d;
      report_q     <= report_d;
      valid_q      <= valid_d;
      pulse_q      <= pulse_d;
    end
  end

  assign REPORT        = report_q;
  assign REPORT_VALID  = valid_q;
  assign TIMEOUT_PULSE = pulse_q;
  assign STATE         = state_q;

endmodule
